// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: opcode encoding and
// the reserved-opcode predicate used to flag unsupported operations.
package shifter_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ROL = 3'b000,
        OP_SLL = 3'b001,
        OP_SRA = 3'b010,
        OP_SRL = 3'b011,
        OP_ROR = 3'b100
    } op_e;

    // Encodings above OP_ROR pass the operand through and raise out_err.
    function automatic logic is_reserved(input logic [OP_W-1:0] op);
        return op > OP_ROR;
    endfunction

endpackage

// File: rtl/shifter_pipe_if.sv
// Operation/result bus of shifter_pipe; the master drives operations and
// consumes results, the slave is the shifter itself.
interface shifter_pipe_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    localparam int CNT_W = $clog2(WIDTH);

    // valid/ready: a transfer happens on a rising edge where valid and ready
    // are both high; valid and its payload hold until that edge, ready never
    // waits on valid, and ready may depend combinationally on the far side.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [CNT_W-1:0] in_cnt;
    logic [2:0]       in_op;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, in_data, in_cnt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_data, in_cnt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_err
    );

endinterface

// File: rtl/shifter_stage.sv
// One pipeline stage: conditionally shifts/rotates by SHAMT when the matching
// count bit is set, then registers the payload and its valid flag.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4,
    parameter int CNT_W = $clog2(WIDTH),
    parameter int SHAMT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             load,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic [CNT_W-1:0] up_cnt,
    input  logic [OP_W-1:0]  up_op,
    input  logic [TAG_W-1:0] up_tag,
    input  logic             up_err,
    output logic             valid_q,
    output logic [WIDTH-1:0] dn_data,
    output logic [CNT_W-1:0] dn_cnt,
    output logic [OP_W-1:0]  dn_op,
    output logic [TAG_W-1:0] dn_tag,
    output logic             dn_err
);

    localparam int BIT = $clog2(SHAMT);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [CNT_W-1:0] cnt;
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] tag;
        logic             err;
    } payload_t;

    payload_t         pay_d, pay_q;
    logic             valid_d;
    logic [WIDTH-1:0] step;

    // SRA fills from this stage's input MSB; earlier stages keep the MSB intact.
    always_comb begin
        step = up_data;
        if (!up_err && up_cnt[BIT]) begin
            case (up_op)
                OP_ROL:  step = (up_data << SHAMT) | (up_data >> (WIDTH - SHAMT));
                OP_SLL:  step = up_data << SHAMT;
                OP_SRA:  step = $signed(up_data) >>> SHAMT;
                OP_SRL:  step = up_data >> SHAMT;
                OP_ROR:  step = (up_data >> SHAMT) | (up_data << (WIDTH - SHAMT));
                default: step = up_data;
            endcase
        end
    end

    always_comb begin
        valid_d = valid_q;
        pay_d   = pay_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = up_valid;
            if (up_valid) begin
                pay_d = '{data: step, cnt: up_cnt, op: up_op, tag: up_tag, err: up_err};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pay_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pay_q   <= pay_d;
        end
    end

    assign dn_data = pay_q.data;
    assign dn_cnt  = pay_q.cnt;
    assign dn_op   = pay_q.op;
    assign dn_tag  = pay_q.tag;
    assign dn_err  = pay_q.err;

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter/rotator: one registered stage per shift-amount bit,
// chained through a combinational ready path so full throughput is kept.
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    shifter_pipe_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

    // Index 0 is the input port; index k+1 is the register of stage k.
    logic [CNT_W:0]   valid_s;
    logic [WIDTH-1:0] data_s [CNT_W+1];
    logic [CNT_W-1:0] cnt_s  [CNT_W+1];
    logic [OP_W-1:0]  op_s   [CNT_W+1];
    logic [TAG_W-1:0] tag_s  [CNT_W+1];
    logic [CNT_W:0]   err_s;
    logic [CNT_W-1:0] load_s;
    logic             unused_tail;

    assign valid_s[0] = bus.in_valid;
    assign data_s[0]  = bus.in_data;
    assign cnt_s[0]   = bus.in_cnt;
    assign op_s[0]    = bus.in_op;
    assign tag_s[0]   = bus.in_tag;
    assign err_s[0]   = is_reserved(bus.in_op);

    // A stage may load when it is empty or when its successor loads this cycle.
    always_comb begin : ready_chain
        logic chain;
        chain  = bus.out_ready;
        load_s = '0;
        for (int k = CNT_W - 1; k >= 0; k--) begin
            load_s[k] = !valid_s[k + 1] || chain;
            chain     = load_s[k];
        end
    end

    for (genvar k = 0; k < CNT_W; k++) begin : g_stage
        shifter_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .CNT_W (CNT_W),
            .SHAMT (1 << k)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .load     (load_s[k]),
            .up_valid (valid_s[k]),
            .up_data  (data_s[k]),
            .up_cnt   (cnt_s[k]),
            .up_op    (op_s[k]),
            .up_tag   (tag_s[k]),
            .up_err   (err_s[k]),
            .valid_q  (valid_s[k + 1]),
            .dn_data  (data_s[k + 1]),
            .dn_cnt   (cnt_s[k + 1]),
            .dn_op    (op_s[k + 1]),
            .dn_tag   (tag_s[k + 1]),
            .dn_err   (err_s[k + 1])
        );
    end

    assign bus.in_ready  = load_s[0];
    assign bus.out_valid = valid_s[CNT_W];
    assign bus.out_data  = data_s[CNT_W];
    assign bus.out_tag   = tag_s[CNT_W];
    assign bus.out_err   = err_s[CNT_W];

    // Count and opcode are only needed inside the pipeline, not at the output.
    assign unused_tail = ^{cnt_s[CNT_W], op_s[CNT_W]};

endmodule
